// File: rtl/pulse_scan_sequencer.sv
`timescale 1ns/1ps
// Scan sequencer driving the fire_pulse/pulser_ready injector handshake and scoring returned halfstrip patterns.
// Define STOP_ON_ERROR_EN to stop at the first miss/wrong pulse and expose fail_distrip, fail_pattern, stop_err.
module pulse_scan_sequencer #(
  parameter int HS_TIMEOUT = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] num_pulses,
  input  logic [3:0]  distrip_first,
  input  logic [3:0]  distrip_last,
  input  logic        hs_sel,
  output logic        fire_pulse,
  input  logic        pulser_ready,
  input  logic [31:0] halfstrips,
  output logic [7:0]  distrip,
  output logic [31:0] halfstrips_expect,
  output logic        busy,
  output logic        done,
  output logic        hs_error,
  output logic [31:0] match_cnt,
  output logic [31:0] miss_cnt,
  output logic [31:0] wrong_cnt
`ifdef STOP_ON_ERROR_EN
  ,
  output logic [3:0]  fail_distrip,
  output logic [31:0] fail_pattern,
  output logic        stop_err
`endif
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WAIT_RDY = 4'd1;
  localparam logic [3:0] S_FIRE     = 4'd2;
  localparam logic [3:0] S_RELEASE  = 4'd3;
  localparam logic [3:0] S_CHECK    = 4'd4;
  localparam logic [3:0] S_GAP      = 4'd5;
  localparam logic [3:0] S_NEXT     = 4'd6;
  localparam logic [3:0] S_DONE     = 4'd7;
  localparam logic [3:0] S_ERROR    = 4'd8;

  localparam int TO_W  = (HS_TIMEOUT > 1) ? $clog2(HS_TIMEOUT) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [3:0]       state;
  logic [3:0]       distrip_q;
  logic [3:0]       last_q;
  logic             single_q;
  logic             hs_sel_q;
  logic [15:0]      pulses_q;
  logic [15:0]      pulse_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [31:0]      capture;
  logic             captured;

  logic hit;
  logic to_expired;
  logic gap_over;
  logic last_pulse;
  logic last_distrip;
  logic is_match;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] onehot_hs(input logic [3:0] d, input logic s);
    return 32'd1 << {d, s};
  endfunction

  assign hit          = (halfstrips != 32'd0);
  // to_cnt holds cycles already waited; the current cycle is number to_cnt+1.
  assign to_expired   = (int'(to_cnt) + 1 >= HS_TIMEOUT);
  assign gap_over     = (int'(gap_cnt) + 1 >= GAP_CYCLES);
  assign last_pulse   = (pulse_cnt + 16'd1 == pulses_q);
  assign last_distrip = single_q || (distrip_q == last_q);
  assign is_match     = captured && (capture == halfstrips_expect);

  assign fire_pulse = (state == S_FIRE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE) || (state == S_ERROR);
  assign distrip    = {4'd0, distrip_q};

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      distrip_q         <= 4'd0;
      last_q            <= 4'd0;
      single_q          <= 1'b0;
      hs_sel_q          <= 1'b0;
      pulses_q          <= 16'd1;
      pulse_cnt         <= 16'd0;
      to_cnt            <= '0;
      gap_cnt           <= '0;
      capture           <= 32'd0;
      captured          <= 1'b0;
      halfstrips_expect <= 32'd1;
      hs_error          <= 1'b0;
      match_cnt         <= 32'd0;
      miss_cnt          <= 32'd0;
      wrong_cnt         <= 32'd0;
`ifdef STOP_ON_ERROR_EN
      fail_distrip      <= 4'd0;
      fail_pattern      <= 32'd0;
      stop_err          <= 1'b0;
`endif
    end else if (abort) begin
      // Abort outranks every transition and leaves the counters readable.
      state <= S_IDLE;
    end else begin
      if ((state == S_FIRE || state == S_RELEASE) && !captured && hit) begin
        capture  <= halfstrips;
        captured <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            match_cnt         <= 32'd0;
            miss_cnt          <= 32'd0;
            wrong_cnt         <= 32'd0;
            hs_error          <= 1'b0;
            distrip_q         <= distrip_first;
            last_q            <= distrip_last;
            single_q          <= (distrip_last < distrip_first);
            hs_sel_q          <= hs_sel;
            pulses_q          <= (num_pulses == 16'd0) ? 16'd1 : num_pulses;
            pulse_cnt         <= 16'd0;
            halfstrips_expect <= onehot_hs(distrip_first, hs_sel);
`ifdef STOP_ON_ERROR_EN
            stop_err          <= 1'b0;
`endif
            state             <= S_WAIT_RDY;
          end
        end

        S_WAIT_RDY: begin
          if (pulser_ready) begin
            capture  <= 32'd0;
            captured <= 1'b0;
            to_cnt   <= '0;
            state    <= S_FIRE;
          end
        end

        S_FIRE: begin
          if (!pulser_ready) begin
            to_cnt <= '0;
            state  <= S_RELEASE;
          end else if (to_expired) begin
            hs_error <= 1'b1;
            state    <= S_ERROR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_RELEASE: begin
          if (pulser_ready) begin
            state <= S_CHECK;
          end else if (to_expired) begin
            hs_error <= 1'b1;
            state    <= S_ERROR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_CHECK: begin
          if (!captured)     miss_cnt  <= sat_inc(miss_cnt);
          else if (is_match) match_cnt <= sat_inc(match_cnt);
          else               wrong_cnt <= sat_inc(wrong_cnt);
          gap_cnt <= '0;
          state   <= S_GAP;
`ifdef STOP_ON_ERROR_EN
          if (!is_match) begin
            fail_distrip <= distrip_q;
            fail_pattern <= capture;
            stop_err     <= 1'b1;
            state        <= S_DONE;
          end
`endif
        end

        S_GAP: begin
          if (gap_over) state <= S_NEXT;
          else          gap_cnt <= gap_cnt + 1'b1;
        end

        S_NEXT: begin
          if (last_pulse) begin
            pulse_cnt <= 16'd0;
            if (last_distrip) begin
              state <= S_DONE;
            end else begin
              distrip_q         <= distrip_q + 4'd1;
              halfstrips_expect <= onehot_hs(distrip_q + 4'd1, hs_sel_q);
              state             <= S_WAIT_RDY;
            end
          end else begin
            pulse_cnt <= pulse_cnt + 16'd1;
            state     <= S_WAIT_RDY;
          end
        end

        S_DONE:  state <= S_IDLE;
        S_ERROR: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_scan_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for pulse_scan_sequencer: an injector model answers each fire_pulse and per-scan
// expectations are queued at start and compared when done pulses.
module tb_pulse_scan_sequencer;

  localparam int HS_TIMEOUT = 16;
  localparam int GAP_CYCLES = 4;
  localparam int M_EXPECT   = 0;
  localparam int M_ZERO     = 1;
  localparam int M_CONST    = 2;
  localparam int M_BAD_AT9  = 3;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] num_pulses;
  logic [3:0]  distrip_first;
  logic [3:0]  distrip_last;
  logic        hs_sel;
  logic        fire_pulse;
  logic        pulser_ready;
  logic [31:0] halfstrips;
  logic [7:0]  distrip;
  logic [31:0] halfstrips_expect;
  logic        busy;
  logic        done;
  logic        hs_error;
  logic [31:0] match_cnt;
  logic [31:0] miss_cnt;
  logic [31:0] wrong_cnt;
`ifdef STOP_ON_ERROR_EN
  logic [3:0]  fail_distrip;
  logic [31:0] fail_pattern;
  logic        stop_err;
`endif

  pulse_scan_sequencer #(
    .HS_TIMEOUT(HS_TIMEOUT),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .num_pulses       (num_pulses),
    .distrip_first    (distrip_first),
    .distrip_last     (distrip_last),
    .hs_sel           (hs_sel),
    .fire_pulse       (fire_pulse),
    .pulser_ready     (pulser_ready),
    .halfstrips       (halfstrips),
    .distrip          (distrip),
    .halfstrips_expect(halfstrips_expect),
    .busy             (busy),
    .done             (done),
    .hs_error         (hs_error),
    .match_cnt        (match_cnt),
    .miss_cnt         (miss_cnt),
    .wrong_cnt        (wrong_cnt)
`ifdef STOP_ON_ERROR_EN
    ,
    .fail_distrip     (fail_distrip),
    .fail_pattern     (fail_pattern),
    .stop_err         (stop_err)
`endif
  );

  typedef struct {
    logic [31:0] match;
    logic [31:0] miss;
    logic [31:0] wrong;
    logic        err;
    int          fires;
    logic        stopped;
    logic [3:0]  fail_d;
    logic [31:0] fail_pat;
  } scan_exp_t;

  scan_exp_t  scan_q[$];
  logic [7:0] pulse_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  int          cur_mode   = M_EXPECT;
  logic [31:0] cur_val    = 32'd0;
  logic        cur_hs     = 1'b0;
  bit          cur_silent = 1'b0;

  int   done_seen  = 0;
  int   fire_rises = 0;
  int   fire_hi    = 0;
  logic fire_prev  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] expect_model(input logic [3:0] d, input logic hs);
    int sh;
    sh = 2 * int'(d) + int'(hs);
    return 32'd1 << sh;
  endfunction

  function automatic logic [31:0] model_pattern(input logic [3:0] d, input logic hs,
                                                input int mode, input logic [31:0] val);
    case (mode)
      M_ZERO:    return 32'd0;
      M_CONST:   return val;
      M_BAD_AT9: return (d == 4'd9) ? val : expect_model(d, hs);
      default:   return expect_model(d, hs);
    endcase
  endfunction

  always @(negedge clk) begin
    if (done) done_seen <= done_seen + 1;
    if (fire_pulse && !fire_prev) fire_rises <= fire_rises + 1;
    if (fire_pulse) fire_hi <= fire_hi + 1;
    fire_prev <= fire_pulse;
  end

  // Injector model: checks the presented distrip, drops ready, returns a pattern, then re-arms.
  initial begin : injector
    logic [7:0]  ed;
    logic [31:0] pat;
    pulser_ready = 1'b1;
    halfstrips   = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (fire_pulse && !cur_silent) begin
        if (pulse_q.size() != 0) ed = pulse_q.pop_front();
        else                     ed = 8'hFF;
        check("fire_distrip", {24'd0, distrip}, {24'd0, ed});
        check("fire_expect", halfstrips_expect, expect_model(ed[3:0], cur_hs));
        pat = model_pattern(ed[3:0], cur_hs, cur_mode, cur_val);
        @(posedge clk); #1;
        pulser_ready = 1'b0;
        halfstrips   = pat;
        for (int i = 0; i < 64 && fire_pulse; i++) begin
          @(posedge clk); #1;
        end
        @(posedge clk); #1;
        halfstrips = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        pulser_ready = 1'b1;
      end
    end
  end

  task automatic kick(input string name, input logic [3:0] first, input logic [3:0] last,
                      input logic [15:0] n, input logic hs);
    @(posedge clk); #1;
    distrip_first = first;
    distrip_last  = last;
    num_pulses    = n;
    hs_sel        = hs;
    start         = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({name, ".clr_match"}, match_cnt, 32'd0);
    check({name, ".clr_miss"},  miss_cnt,  32'd0);
    check({name, ".clr_wrong"}, wrong_cnt, 32'd0);
    check({name, ".clr_err"},   {31'd0, hs_error}, 32'd0);
    check({name, ".busy"},      {31'd0, busy}, 32'd1);
  endtask

  task automatic run_scan(input string name, input logic [3:0] first, input logic [3:0] last,
                          input logic [15:0] n, input logic hs, input int mode,
                          input logic [31:0] val, input bit silent, input bit mid_start);
    scan_exp_t   e;
    scan_exp_t   got_e;
    int          eff_n;
    logic [3:0]  eff_last;
    bit          stop;
    logic [31:0] pat;
    int          base_done;
    int          base_rises;
    int          base_hi;

    eff_n    = (n == 16'd0) ? 1 : int'(n);
    eff_last = (last < first) ? first : last;
    stop     = 1'b0;
    e        = '{default: 0};
    pulse_q.delete();
    if (silent) begin
      e.err   = 1'b1;
      e.fires = 1;
    end else begin
      for (int d = int'(first); d <= int'(eff_last) && !stop; d++) begin
        for (int p = 0; p < eff_n && !stop; p++) begin
          pat = model_pattern(4'(d), hs, mode, val);
          pulse_q.push_back(8'(d));
          e.fires++;
          if (pat == 32'd0) e.miss++;
          else if (pat == expect_model(4'(d), hs)) e.match++;
          else e.wrong++;
`ifdef STOP_ON_ERROR_EN
          if (pat != expect_model(4'(d), hs)) begin
            stop       = 1'b1;
            e.stopped  = 1'b1;
            e.fail_d   = 4'(d);
            e.fail_pat = pat;
          end
`endif
        end
      end
    end
    scan_q.push_back(e);

    cur_mode   = mode;
    cur_val    = val;
    cur_hs     = hs;
    cur_silent = silent;
    base_done  = done_seen;
    base_rises = fire_rises;
    base_hi    = fire_hi;
    kick(name, first, last, n, hs);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (done) break;
      start = (mid_start && cyc == 30);
    end
    start = 1'b0;
    check({name, ".done"}, {31'd0, done}, 32'd1);
    got_e = scan_q.pop_front();
    check({name, ".match"}, match_cnt, got_e.match);
    check({name, ".miss"},  miss_cnt,  got_e.miss);
    check({name, ".wrong"}, wrong_cnt, got_e.wrong);
    check({name, ".hs_error"}, {31'd0, hs_error}, {31'd0, got_e.err});
    check({name, ".fire_at_done"}, {31'd0, fire_pulse}, 32'd0);
`ifdef STOP_ON_ERROR_EN
    check({name, ".stop_err"}, {31'd0, stop_err}, {31'd0, got_e.stopped});
    if (got_e.stopped) begin
      check({name, ".fail_distrip"}, {28'd0, fail_distrip}, {28'd0, got_e.fail_d});
      check({name, ".fail_pattern"}, fail_pattern, got_e.fail_pat);
    end
`endif
    repeat (2) @(negedge clk);
    check({name, ".done_pulses"}, 32'(done_seen - base_done), 32'd1);
    check({name, ".fire_rises"}, 32'(fire_rises - base_rises), 32'(got_e.fires));
    check({name, ".idle"}, {31'd0, busy}, 32'd0);
    if (silent) check({name, ".fire_hi_cycles"}, 32'(fire_hi - base_hi), 32'(HS_TIMEOUT));
    cur_silent = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic abort_scan();
    int base_done;
    int base_rises;
    pulse_q.delete();
    pulse_q.push_back(8'd2);
    pulse_q.push_back(8'd3);
    pulse_q.push_back(8'd4);
    cur_mode   = M_EXPECT;
    cur_hs     = 1'b0;
    cur_silent = 1'b0;
    base_done  = done_seen;
    base_rises = fire_rises;
    kick("abort", 4'd2, 4'd4, 16'd1, 1'b0);
    for (int cyc = 0; cyc < 2000 && fire_rises < base_rises + 3; cyc++) @(negedge clk);
    for (int cyc = 0; cyc < 200 && fire_pulse; cyc++) @(negedge clk);
    check("abort.pre_match", match_cnt, 32'd2);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort.idle", {31'd0, busy}, 32'd0);
    check("abort.fire_low", {31'd0, fire_pulse}, 32'd0);
    check("abort.match_held", match_cnt, 32'd2);
    repeat (8) @(negedge clk);
    check("abort.no_done", 32'(done_seen - base_done), 32'd0);
    check("abort.still_idle", {31'd0, busy}, 32'd0);
    check("abort.match_kept", match_cnt, 32'd2);
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: got no summary, expected completion before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    reset         = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    num_pulses    = 16'd1;
    distrip_first = 4'd0;
    distrip_last  = 4'd0;
    hs_sel        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst.fire",     {31'd0, fire_pulse}, 32'd0);
    check("rst.busy",     {31'd0, busy}, 32'd0);
    check("rst.done",     {31'd0, done}, 32'd0);
    check("rst.hs_error", {31'd0, hs_error}, 32'd0);
    check("rst.match",    match_cnt, 32'd0);
    check("rst.miss",     miss_cnt, 32'd0);
    check("rst.wrong",    wrong_cnt, 32'd0);
    check("rst.distrip",  {24'd0, distrip}, 32'd0);

    run_scan("match3to5", 4'd3, 4'd5, 16'd2, 1'b1, M_EXPECT, 32'd0, 1'b0, 1'b1);
    run_scan("miss0",     4'd0, 4'd0, 16'd4, 1'b0, M_ZERO, 32'd0, 1'b0, 1'b0);
    run_scan("wrong7",    4'd7, 4'd7, 16'd1, 1'b0, M_CONST, 32'h0000_C000, 1'b0, 1'b0);
    run_scan("reversed",  4'd10, 4'd4, 16'd1, 1'b0, M_EXPECT, 32'd0, 1'b0, 1'b0);
    run_scan("zero_n",    4'd1, 4'd2, 16'd0, 1'b1, M_EXPECT, 32'd0, 1'b0, 1'b0);
    run_scan("timeout",   4'd5, 4'd5, 16'd1, 1'b0, M_EXPECT, 32'd0, 1'b1, 1'b0);
    abort_scan();
    run_scan("post_abort", 4'd0, 4'd0, 16'd1, 1'b0, M_EXPECT, 32'd0, 1'b0, 1'b0);
`ifdef STOP_ON_ERROR_EN
    run_scan("stop9", 4'd0, 4'd15, 16'd2, 1'b1, M_BAD_AT9, 32'h0000_0001, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
